vproc_vregpack_acc: RTL and testbench

// - Sequential successor of the vector result packer. Narrows (1:1, 2:1 or 4:1) a stream of
//   OP_W-bit unit results and accumulates 2 or 4 narrowed slices into one full OP_W register word.
// - Sits between the execution-unit result stage and the vector register file write port.

---
 rtl/vproc_pkg.sv | 29 ++
 rtl/vproc_vregpack_slice.sv | 44 ++++
 rtl/vproc_vregpack_acc.sv | 158 +++++++++++++++
 tb/tb_vproc_vregpack_acc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
// Shared vector-unit types: element width, narrowing ratio and the last-slot lookup.
package vproc_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'b00,
    VSEW_16      = 2'b01,
    VSEW_32      = 2'b10,
    VSEW_INVALID = 2'b11
  } cfg_vsew;

  typedef enum logic [1:0] {
    PACK_1 = 2'b00,
    PACK_2 = 2'b01,
    PACK_4 = 2'b10
  } pack_ratio_e;

  localparam int unsigned SLOT_W = 2;

  // Index of the slot that completes a word; unsupported ratios behave like PACK_1.
  function automatic logic [SLOT_W-1:0] pack_last_slot(input pack_ratio_e ratio,
                                                        input int unsigned max_ratio);
    case (ratio)
      PACK_2:  return SLOT_W'(1);
      PACK_4:  return (max_ratio >= 4) ? SLOT_W'(3) : SLOT_W'(0);
      default: return SLOT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/vproc_vregpack_slice.sv
// Narrows one unit result into a low-aligned slice of OP_W/R bits plus its byte mask.
module vproc_vregpack_slice
  import vproc_pkg::*;
#(
  parameter int unsigned OP_W      = 32,
  parameter int unsigned MAX_RATIO = 4
) (
  input  cfg_vsew             vsew,
  input  pack_ratio_e         ratio,
  input  logic [OP_W-1:0]     result,
  input  logic [OP_W/8-1:0]   byte_mask,
  output logic [OP_W-1:0]     slice_data,
  output logic [OP_W/8-1:0]   slice_mask
);

  localparam int unsigned N16 = OP_W / 16;
  localparam int unsigned N32 = OP_W / 32;

  // Each destination element keeps the low bits of its source and inherits the source byte-0 mask.
  always_comb begin
    slice_data = '0;
    slice_mask = '0;
    if (ratio == PACK_1) begin
      slice_data = result;
      slice_mask = byte_mask;
    end else if (ratio == PACK_2 && vsew == VSEW_16) begin
      for (int unsigned i = 0; i < N16; i++) begin
        slice_data[i*8 +: 8] = result[i*16 +: 8];
        slice_mask[i]        = byte_mask[i*2];
      end
    end else if (ratio == PACK_2 && vsew == VSEW_32) begin
      for (int unsigned i = 0; i < N32; i++) begin
        slice_data[i*16 +: 16] = result[i*32 +: 16];
        slice_mask[i*2 +: 2]   = {2{byte_mask[i*4]}};
      end
    end else if (ratio == PACK_4 && vsew == VSEW_32 && MAX_RATIO >= 4) begin
      for (int unsigned i = 0; i < N32; i++) begin
        slice_data[i*8 +: 8] = result[i*32 +: 8];
        slice_mask[i]        = byte_mask[i*4];
      end
    end
  end

endmodule

// File: rtl/vproc_vregpack_acc.sv
// Accumulates narrowed result slices into full vreg words and emits them through a registered
// valid/ready write stage.
module vproc_vregpack_acc
  import vproc_pkg::*;
#(
  parameter int unsigned OP_W      = 32,
  parameter int unsigned MAX_RATIO = 4,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                clk_i,
  input  logic                async_rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  cfg_vsew             in_vsew_i,
  input  pack_ratio_e         in_ratio_i,
  input  logic                in_last_i,
  input  logic [ADDR_W-1:0]   in_addr_i,
  input  logic [OP_W-1:0]     in_result_i,
  input  logic [OP_W/8-1:0]   in_mask_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ADDR_W-1:0]   out_addr_o,
  output logic [OP_W-1:0]     out_data_o,
  output logic [OP_W/8-1:0]   out_mask_o,
  output logic                busy_o
);

  localparam int unsigned MASK_W = OP_W / 8;
  localparam int unsigned SH_W   = $clog2(OP_W);

  logic [SLOT_W-1:0] slot_q, slot_d;
  pack_ratio_e       ratio_q, ratio_d;
  cfg_vsew           vsew_q, vsew_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OP_W-1:0]   acc_data_q, acc_data_d;
  logic [MASK_W-1:0] acc_mask_q, acc_mask_d;
  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   out_data_q, out_data_d;
  logic [MASK_W-1:0] out_mask_q, out_mask_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;

  pack_ratio_e       cur_ratio;
  cfg_vsew           cur_vsew;
  logic              mismatch, complete, out_free, accept, flush;
  logic [SH_W-1:0]   shamt;
  logic [OP_W-1:0]   slice_data, word_data;
  logic [MASK_W-1:0] slice_mask, word_mask;

  // Slot 0 takes the incoming config; later slots use the config latched with the word.
  assign cur_ratio = (slot_q == '0) ? in_ratio_i : ratio_q;
  assign cur_vsew  = (slot_q == '0) ? in_vsew_i  : vsew_q;

  vproc_vregpack_slice #(
    .OP_W      (OP_W),
    .MAX_RATIO (MAX_RATIO)
  ) u_slice (
    .vsew       (cur_vsew),
    .ratio      (cur_ratio),
    .result     (in_result_i),
    .byte_mask  (in_mask_i),
    .slice_data (slice_data),
    .slice_mask (slice_mask)
  );

  always_comb begin
    case (cur_ratio)
      PACK_2:  shamt = slot_q[0] ? SH_W'(OP_W / 2) : '0;
      PACK_4:  shamt = SH_W'(slot_q) * SH_W'(OP_W / 4);
      default: shamt = '0;
    endcase
  end

  assign word_data = acc_data_q | (slice_data << shamt);
  assign word_mask = acc_mask_q | (slice_mask << (shamt >> 3));

  // A config change mid-word stalls the input while the partial word drains to the output.
  assign mismatch   = in_valid_i && (slot_q != '0) &&
                      ((in_ratio_i != ratio_q) || (in_addr_i != addr_q));
  assign complete   = (slot_q == pack_last_slot(cur_ratio, MAX_RATIO)) || in_last_i;
  assign out_free   = !out_valid_q || out_ready_i;
  assign in_ready_o = !mismatch && (!complete || out_free);
  assign accept     = in_valid_i && in_ready_o;
  assign flush      = mismatch && out_free;

  always_comb begin
    slot_d      = slot_q;
    ratio_d     = ratio_q;
    vsew_d      = vsew_q;
    addr_d      = addr_q;
    acc_data_d  = acc_data_q;
    acc_mask_d  = acc_mask_q;
    out_valid_d = out_valid_q && !out_ready_i;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_addr_d  = out_addr_q;
    if (accept) begin
      if (slot_q == '0) begin
        ratio_d = in_ratio_i;
        vsew_d  = in_vsew_i;
        addr_d  = in_addr_i;
      end
      if (complete) begin
        out_valid_d = 1'b1;
        out_data_d  = word_data;
        out_mask_d  = word_mask;
        out_addr_d  = in_addr_i;
        acc_data_d  = '0;
        acc_mask_d  = '0;
        slot_d      = '0;
      end else begin
        acc_data_d = word_data;
        acc_mask_d = word_mask;
        slot_d     = SLOT_W'(slot_q + 1'b1);
      end
    end else if (flush) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data_q;
      out_mask_d  = acc_mask_q;
      out_addr_d  = addr_q;
      acc_data_d  = '0;
      acc_mask_d  = '0;
      slot_d      = '0;
    end
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      slot_q      <= '0;
      ratio_q     <= PACK_1;
      vsew_q      <= VSEW_8;
      addr_q      <= '0;
      acc_data_q  <= '0;
      acc_mask_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      slot_q      <= slot_d;
      ratio_q     <= ratio_d;
      vsew_q      <= vsew_d;
      addr_q      <= addr_d;
      acc_data_q  <= acc_data_d;
      acc_mask_q  <= acc_mask_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_mask_o  = out_mask_q;
  assign out_addr_o  = out_addr_q;
  assign busy_o      = (slot_q != '0) || out_valid_q;

endmodule

// File: tb/tb_vproc_vregpack_acc.sv
// Directed bench for vproc_vregpack_acc: per-cycle vector table plus mismatch, backpressure and reset sequences.
module tb_vproc_vregpack_acc;
  import vproc_pkg::*;

  logic        clk_i = 1'b0;
  logic        async_rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  cfg_vsew     in_vsew_i;
  pack_ratio_e in_ratio_i;
  logic        in_last_i;
  logic [4:0]  in_addr_i;
  logic [31:0] in_result_i;
  logic [3:0]  in_mask_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  out_addr_o;
  logic [31:0] out_data_o;
  logic [3:0]  out_mask_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  vproc_vregpack_acc #(.OP_W(32), .MAX_RATIO(4), .ADDR_W(5)) dut (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_vsew_i   (in_vsew_i),
    .in_ratio_i  (in_ratio_i),
    .in_last_i   (in_last_i),
    .in_addr_i   (in_addr_i),
    .in_result_i (in_result_i),
    .in_mask_i   (in_mask_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_addr_o  (out_addr_o),
    .out_data_o  (out_data_o),
    .out_mask_o  (out_mask_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    pack_ratio_e ratio;
    cfg_vsew     vsew;
    logic        last;
    logic [4:0]  addr;
    logic [31:0] res;
    logic [3:0]  msk;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_data;
    logic [3:0]  e_mask;
    logic [4:0]  e_addr;
    logic        e_busy;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic v, input pack_ratio_e r, input cfg_vsew s, input logic l,
                              input logic [4:0] a, input logic [31:0] d, input logic [3:0] m,
                              input logic e_rdy, input logic e_ov, input logic [31:0] e_data,
                              input logic [3:0] e_mask, input logic [4:0] e_addr, input logic e_busy);
    vec_t x;
    x.valid = v;   x.ratio = r;   x.vsew = s;   x.last = l;
    x.addr = a;    x.res = d;     x.msk = m;    x.ordy = 1'b1;
    x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_data = e_data;
    x.e_mask = e_mask; x.e_addr = e_addr; x.e_busy = e_busy;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input pack_ratio_e r, input cfg_vsew s, input logic l,
                       input logic [4:0] a, input logic [31:0] d, input logic [3:0] m, input logic ordy);
    in_valid_i = v; in_ratio_i = r; in_vsew_i = s; in_last_i = l;
    in_addr_i = a;  in_result_i = d; in_mask_i = m; out_ready_i = ordy;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, PACK_1, VSEW_8, 1'b0, 5'd0, 32'h0, 4'h0, ordy);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] d, input logic [3:0] m, input logic [4:0] a);
    check({tag, " out_valid"}, out_valid_o, 1);
    check({tag, " out_data"}, out_data_o, d);
    check({tag, " out_mask"}, out_mask_o, m);
    check({tag, " out_addr"}, out_addr_o, a);
  endtask

  int          tx, rx, late_stall;
  logic [31:0] expq[$];
  logic [31:0] exp_word;
  logic        hs, acc;

  initial begin
    vecs[0]  = mk(1, PACK_2, VSEW_16, 0, 5'd3, 32'h1122_3344, 4'hF, 1, 0, 32'h0,         4'h0,    5'd0, 1);
    vecs[1]  = mk(1, PACK_2, VSEW_16, 1, 5'd3, 32'h5566_7788, 4'hF, 1, 1, 32'h6688_2244, 4'hF,    5'd3, 1);
    vecs[2]  = mk(0, PACK_1, VSEW_8,  0, 5'd0, 32'h0,         4'h0, 1, 0, 32'h0,         4'h0,    5'd0, 0);
    vecs[3]  = mk(1, PACK_4, VSEW_32, 0, 5'd5, 32'h0000_00AA, 4'h1, 1, 0, 32'h0,         4'h0,    5'd0, 1);
    vecs[4]  = mk(1, PACK_4, VSEW_32, 0, 5'd5, 32'h1234_56BB, 4'h1, 1, 0, 32'h0,         4'h0,    5'd0, 1);
    vecs[5]  = mk(1, PACK_4, VSEW_32, 0, 5'd5, 32'hFFFF_FFCC, 4'h1, 1, 0, 32'h0,         4'h0,    5'd0, 1);
    vecs[6]  = mk(1, PACK_4, VSEW_32, 0, 5'd5, 32'h0000_00DD, 4'h1, 1, 1, 32'hDDCC_BBAA, 4'hF,    5'd5, 1);
    vecs[7]  = mk(1, PACK_2, VSEW_32, 1, 5'd7, 32'h0000_BEEF, 4'hF, 1, 1, 32'h0000_BEEF, 4'b0011, 5'd7, 1);
    vecs[8]  = mk(1, PACK_1, VSEW_8,  0, 5'd1, 32'hCAFE_F00D, 4'h5, 1, 1, 32'hCAFE_F00D, 4'h5,    5'd1, 1);
    vecs[9]  = mk(1, PACK_4, VSEW_16, 1, 5'd2, 32'hFFFF_FFFF, 4'hF, 1, 1, 32'h0,         4'h0,    5'd2, 1);
    vecs[10] = mk(1, PACK_2, VSEW_16, 1, 5'd4, 32'hAABB_CCDD, 4'h4, 1, 1, 32'h0000_BBDD, 4'b0010, 5'd4, 1);
    vecs[11] = mk(1, PACK_4, VSEW_32, 0, 5'd6, 32'h0000_0011, 4'hF, 1, 1, 32'h0000_BBDD, 4'b0010, 5'd4, 1);
    vecs[12] = mk(1, PACK_4, VSEW_32, 1, 5'd6, 32'h0000_0022, 4'hF, 1, 1, 32'h0000_2211, 4'b0011, 5'd6, 1);
    vecs[13] = mk(0, PACK_1, VSEW_8,  0, 5'd0, 32'h0,         4'h0, 1, 0, 32'h0,         4'h0,    5'd0, 0);
    // vecs[11]: previous word handshakes and the new partial word is not yet complete
    vecs[11].e_ov = 1'b0;

    async_rst_i = 1'b1;
    idle(1'b1);
    tick();
    tick();
    check("reset out_valid", out_valid_o, 0);
    check("reset out_data", out_data_o, 0);
    check("reset out_mask", out_mask_o, 0);
    check("reset out_addr", out_addr_o, 0);
    check("reset busy", busy_o, 0);
    async_rst_i = 1'b0;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].ratio, vecs[i].vsew, vecs[i].last, vecs[i].addr,
            vecs[i].res, vecs[i].msk, vecs[i].ordy);
      #1;
      check($sformatf("v%0d in_ready", i), in_ready_o, vecs[i].e_rdy);
      tick();
      check($sformatf("v%0d out_valid", i), out_valid_o, vecs[i].e_ov);
      check($sformatf("v%0d busy", i), busy_o, vecs[i].e_busy);
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d out_data", i), out_data_o, vecs[i].e_data);
        check($sformatf("v%0d out_mask", i), out_mask_o, vecs[i].e_mask);
        check($sformatf("v%0d out_addr", i), out_addr_o, vecs[i].e_addr);
      end
    end

    // Address change on slot 1 flushes the partial word, then restarts at slot 0
    drive(1, PACK_2, VSEW_16, 0, 5'd1, 32'h0000_1234, 4'hF, 1);
    #1; check("mm accept first", in_ready_o, 1);
    tick();
    check("mm no early out", out_valid_o, 0);
    drive(1, PACK_2, VSEW_16, 0, 5'd2, 32'h0000_5678, 4'hF, 1);
    #1; check("mm stall in_ready", in_ready_o, 0);
    tick();
    check_out("mm flush", 32'h0000_0034, 4'b0011, 5'd1);
    #1; check("mm retry in_ready", in_ready_o, 1);
    tick();
    check("mm flush drained", out_valid_o, 0);
    check("mm busy slot1", busy_o, 1);
    drive(1, PACK_2, VSEW_16, 1, 5'd2, 32'h0000_9ABC, 4'hF, 1);
    tick();
    check_out("mm new word", 32'h00BC_0078, 4'hF, 5'd2);
    idle(1'b1);
    tick();

    // PACK_1 stream with the write port stalled for the first cycles
    tx = 0; rx = 0; late_stall = 0;
    for (int t = 0; t < 40 && rx < 6; t++) begin
      drive(tx < 6, PACK_1, VSEW_32, 0, 5'(tx), 32'hD000_0000 + 32'(tx), 4'hF, t >= 4);
      #1;
      if (t >= 1 && t <= 3) begin
        check($sformatf("bp t%0d in_ready", t), in_ready_o, 0);
        check_out($sformatf("bp t%0d held", t), 32'hD000_0000, 4'hF, 5'd0);
      end
      if (t >= 4 && in_valid_i && !in_ready_o) late_stall++;
      hs  = out_valid_o && out_ready_i;
      acc = in_valid_i && in_ready_o;
      if (hs) begin
        if (expq.size() == 0) begin
          check("bp spurious word", out_data_o, 32'hFFFF_FFFF);
        end else begin
          exp_word = expq.pop_front();
          check($sformatf("bp word%0d data", rx), out_data_o, exp_word);
          check($sformatf("bp word%0d addr", rx), out_addr_o, {27'd0, exp_word[4:0]});
        end
        rx++;
      end
      if (acc) begin
        expq.push_back(in_result_i);
        tx++;
      end
      tick();
    end
    check("bp words sent", tx, 6);
    check("bp words received", rx, 6);
    check("bp stalls at full rate", late_stall, 0);
    idle(1'b1);
    tick();
    check("bp drained", out_valid_o, 0);

    // Async reset with a partial word and a stalled output pending
    drive(1, PACK_1, VSEW_32, 0, 5'd9, 32'h1234_5678, 4'hF, 0);
    tick();
    drive(1, PACK_2, VSEW_16, 0, 5'd3, 32'h0000_AB12, 4'hF, 0);
    #1; check("rst partial accepted in stall", in_ready_o, 1);
    tick();
    check_out("rst pre", 32'h1234_5678, 4'hF, 5'd9);
    check("rst pre busy", busy_o, 1);
    idle(1'b1);
    #1; async_rst_i = 1'b1;
    #1;
    check("rst out_valid", out_valid_o, 0);
    check("rst out_data", out_data_o, 0);
    check("rst out_mask", out_mask_o, 0);
    check("rst out_addr", out_addr_o, 0);
    check("rst busy", busy_o, 0);
    tick();
    async_rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst quiet c%0d", k), out_valid_o, 0);
    end
    drive(1, PACK_2, VSEW_16, 1, 5'd3, 32'h0000_AB12, 4'hF, 1);
    tick();
    check_out("rst slot0 restart", 32'h0000_0012, 4'b0011, 5'd3);
    idle(1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
